pps_nco_timer: RTL

- Parametrised successor to the single-rate PPS timer, for the same timing path.
- An NCO accumulator produces a tick whenever it carries. Each tick advances a free-running time counter and a programmable PPS divider, which drives a PPS output with programmable pulse width.
- A bank of NSEL runtime-writable increment registers is selected by a step pulse or by a direct load.
- Rising edges of pps_in capture the time counter into a valid/ready timestamp port that reports overruns.

---
 rtl/pps_timer_pkg.sv | 25 ++
 rtl/pps_nco_timer_if.sv | 46 ++++
 rtl/pps_edge_sync.sv | 37 +++
 rtl/pps_nco_timer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pps_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pps_timer_pkg
// Brief    : Shared constants and types for the PPS NCO timer.
// Revision : 1.0  initial release
// ============================================================================
package pps_timer_pkg;

    // Selection index width and synchroniser depth
    localparam int SEL_W      = 4;
    localparam int SYNC_DEPTH = 2;

    // Configuration map entries above the increment bank
    localparam logic [4:0] ADDR_PPS_COUNT = 5'd16;
    localparam logic [4:0] ADDR_PULSE_W   = 5'd17;

    typedef logic [SEL_W-1:0] sel_t;

    // Wider of two widths, used to size the config data bus
    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pps_nco_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : pps_nco_timer_if
// Brief    : Config, selection, PPS and timestamp signals of the PPS NCO timer.
//            master = controlling side, slave = timer.
// Revision : 1.0  initial release
// ============================================================================
interface pps_nco_timer_if
    import pps_timer_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int TS_W  = 64,
    parameter int CNT_W = 32
);
    localparam int DATA_W = max_w(ACC_W, CNT_W);

    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              sel_step;
    logic              sel_load;
    sel_t              sel_in;
    sel_t              incr_sel;
    logic              pps_in;
    logic              pps_pulse_out;
    logic              tick;
    logic [TS_W-1:0]   ts_data;
    logic              ts_valid;
    logic              ts_ready;
    logic              ts_overrun;
    logic              ts_overrun_clr;

    modport master (
        output wr_en, wr_addr, wr_data, sel_step, sel_load, sel_in,
               pps_in, ts_ready, ts_overrun_clr,
        input  incr_sel, pps_pulse_out, tick, ts_data, ts_valid, ts_overrun
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, sel_step, sel_load, sel_in,
               pps_in, ts_ready, ts_overrun_clr,
        output incr_sel, pps_pulse_out, tick, ts_data, ts_valid, ts_overrun
    );

endinterface
`default_nettype wire

// File: rtl/pps_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : pps_edge_sync
// Brief    : Synchroniser chain for the asynchronous PPS reference followed by
//            a registered single-cycle rising-edge pulse.
// Revision : 1.0  initial release
// ============================================================================
module pps_edge_sync
    import pps_timer_pkg::*;
(
    input  wire logic clk_pps,
    input  wire logic reset_pps,
    input  wire logic pps_in,
    output logic      pps_rise
);

    logic [SYNC_DEPTH-1:0] r_sync;
    logic                  r_prev;
    logic                  r_rise;

    // Shift the reference through the chain and register the rising edge
    always_ff @(posedge clk_pps) begin
        if (reset_pps) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], pps_in};
            r_prev <= r_sync[SYNC_DEPTH-1];
            r_rise <= r_sync[SYNC_DEPTH-1] & ~r_prev;
        end
    end

    assign pps_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/pps_nco_timer.sv
`default_nettype none
// ============================================================================
// Module   : pps_nco_timer
// Brief    : NCO-driven time counter and programmable PPS generator with a
//            selectable increment bank and optional PPS timestamp capture.
//            Build option: define PPS_NCO_TS_EN to include the capture path.
// Revision : 1.0  initial release
// ============================================================================
module pps_nco_timer
    import pps_timer_pkg::*;
#(
    parameter int                ACC_W         = 32,
    parameter int                TS_W          = 64,
    parameter int unsigned       TIME_INCR     = 10,
    parameter int                NSEL          = 4,
    parameter int                CNT_W         = 32,
    parameter logic [ACC_W-1:0]  A_INCR_RST    = ACC_W'(32'h8000_0000),
    parameter logic [CNT_W-1:0]  PPS_COUNT_RST = CNT_W'(100000),
    parameter logic [CNT_W-1:0]  PULSE_W_RST   = CNT_W'(25000)
)(
    input  wire logic        clk_pps,
    input  wire logic        reset_pps,
    pps_nco_timer_if.slave   bus
);

    localparam int         IDX_W         = (NSEL > 1) ? $clog2(NSEL) : 1;
    localparam sel_t       SEL_LAST      = sel_t'(NSEL - 1);
    localparam logic [4:0] INCR_ADDR_END = 5'(NSEL);

    logic [ACC_W-1:0] r_incr [NSEL];
    logic [CNT_W-1:0] r_pps_count;
    logic [CNT_W-1:0] r_pulse_w;
    sel_t             r_sel;
    logic [ACC_W-1:0] r_acc;
    logic             r_tick;
    logic [TS_W-1:0]  r_time;
    logic [CNT_W-1:0] r_pps_ctr;
    logic             r_pps_out;

    logic [IDX_W-1:0] w_idx;
    logic [ACC_W:0]   w_sum;
    logic [CNT_W-1:0] w_cnt_eff;
    logic             w_ctr_wrap;

    assign w_idx      = r_sel[IDX_W-1:0];
    assign w_sum      = {1'b0, r_acc} + {1'b0, r_incr[w_idx]};
    // A zero period behaves as a period of one tick
    assign w_cnt_eff  = (r_pps_count == '0) ? CNT_W'(1) : r_pps_count;
    // >= so a period shrunk below the running count still wraps on the next tick
    assign w_ctr_wrap = (r_pps_ctr >= (w_cnt_eff - CNT_W'(1)));

    // Configuration writes into the increment bank and divider settings
    always_ff @(posedge clk_pps) begin
        if (reset_pps) begin
            for (int i = 0; i < NSEL; i++) begin
                r_incr[i] <= A_INCR_RST;
            end
            r_pps_count <= PPS_COUNT_RST;
            r_pulse_w   <= PULSE_W_RST;
        end else if (bus.wr_en) begin
            if (bus.wr_addr < INCR_ADDR_END) begin
                r_incr[bus.wr_addr[IDX_W-1:0]] <= bus.wr_data[ACC_W-1:0];
            end else if (bus.wr_addr == ADDR_PPS_COUNT) begin
                r_pps_count <= bus.wr_data[CNT_W-1:0];
            end else if (bus.wr_addr == ADDR_PULSE_W) begin
                r_pulse_w <= bus.wr_data[CNT_W-1:0];
            end
        end
    end

    // Increment selection: direct load has priority over stepping
    always_ff @(posedge clk_pps) begin
        if (reset_pps) begin
            r_sel <= '0;
        end else if (bus.sel_load) begin
            if (bus.sel_in <= SEL_LAST) begin
                r_sel <= bus.sel_in;
            end
        end else if (bus.sel_step) begin
            r_sel <= (r_sel == SEL_LAST) ? '0 : r_sel + sel_t'(1);
        end
    end

    // NCO accumulator; the carry out becomes the registered tick
    always_ff @(posedge clk_pps) begin
        if (reset_pps) begin
            r_acc  <= '0;
            r_tick <= 1'b0;
        end else begin
            {r_tick, r_acc} <= w_sum;
        end
    end

    // Per-tick time counter, PPS divider and pulse shaping
    always_ff @(posedge clk_pps) begin
        if (reset_pps) begin
            r_time    <= '0;
            r_pps_ctr <= '0;
            r_pps_out <= 1'b0;
        end else if (r_tick) begin
            r_time    <= r_time + TS_W'(TIME_INCR);
            r_pps_ctr <= w_ctr_wrap ? '0 : r_pps_ctr + CNT_W'(1);
            r_pps_out <= (r_pps_ctr < r_pulse_w);
        end
    end

    assign bus.incr_sel      = r_sel;
    assign bus.tick          = r_tick;
    assign bus.pps_pulse_out = r_pps_out;

`ifdef PPS_NCO_TS_EN
    logic            w_rise;
    logic [TS_W-1:0] r_ts_data;
    logic            r_ts_valid;
    logic            r_ts_overrun;

    pps_edge_sync u_edge_sync (
        .clk_pps   (clk_pps),
        .reset_pps (reset_pps),
        .pps_in    (bus.pps_in),
        .pps_rise  (w_rise)
    );

    // Timestamp holding register with valid/ready handshake and overrun flag
    always_ff @(posedge clk_pps) begin
        if (reset_pps) begin
            r_ts_data    <= '0;
            r_ts_valid   <= 1'b0;
            r_ts_overrun <= 1'b0;
        end else begin
            if (w_rise && (!r_ts_valid || bus.ts_ready)) begin
                r_ts_data  <= r_time;
                r_ts_valid <= 1'b1;
            end else if (r_ts_valid && bus.ts_ready) begin
                r_ts_valid <= 1'b0;
            end
            // A fresh overrun outranks a clear in the same cycle
            if (w_rise && r_ts_valid && !bus.ts_ready) begin
                r_ts_overrun <= 1'b1;
            end else if (bus.ts_overrun_clr) begin
                r_ts_overrun <= 1'b0;
            end
        end
    end

    assign bus.ts_data    = r_ts_data;
    assign bus.ts_valid   = r_ts_valid;
    assign bus.ts_overrun = r_ts_overrun;
`else
    logic w_unused_ts;
    assign w_unused_ts    = &{1'b0, bus.pps_in, bus.ts_ready, bus.ts_overrun_clr};
    assign bus.ts_data    = '0;
    assign bus.ts_valid   = 1'b0;
    assign bus.ts_overrun = 1'b0;
`endif

endmodule
`default_nettype wire
